// File: rtl/alu_op_sched.sv
// Two-requester round-robin scheduler that drives a multi-cycle ALU and returns one response per command.
// Optional macro ALU_SCHED_ONEHOT_CHK_EN rejects commands whose op select is not exactly one-hot.
module alu_op_sched #(
  parameter int unsigned LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       alu_on,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_out,
  output logic       busy,
  output logic [1:0] state
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

`ifdef ALU_SCHED_ONEHOT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_q, gnt_d;
  logic               prio_q, prio_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DW-1:0]      num1_q, num1_d;
  logic [DW-1:0]      num2_q, num2_d;
  logic [OP_W-1:0]    out_sel_q, out_sel_d;
  logic [2:0]         in_sel_q, in_sel_d;
  logic               rsp0_q, rsp0_d;
  logic               rsp1_q, rsp1_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               alu_on_q;
  logic               pick1_c;

  // An op is rejected only when checking is built in and it is not exactly one-hot.
  function automatic logic op_bad(input logic [OP_W-1:0] op);
    return CHK_EN && ((op == '0) || ((op & (op - OP_W'(1))) != '0));
  endfunction

  // Requester 1 wins when it alone is valid, or on a tie when it holds priority.
  assign pick1_c    = req1_valid && (!req0_valid || prio_q);
  assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !pick1_c;
  assign req1_ready = !rst && (state_q == IDLE) && pick1_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    prio_d     = prio_q;
    op_d       = op_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = pick1_c;
          prio_d  = !pick1_c;
          op_d    = pick1_c ? req1_op : req0_op;
          num1_d  = pick1_c ? req1_a  : req0_a;
          num2_d  = pick1_c ? req1_b  : req0_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (op_bad(op_q)) begin
          state_d    = DONE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          state_d = EXEC;
          cnt_d   = CNT_W'(LAT);
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered.
    in_sel_d  = ((state_d == LOAD) && !op_bad(op_d)) ? SEL_LOAD : SEL_PERSIST;
    out_sel_d = ((state_d == LOAD) || (state_d == EXEC)) ? op_d : '0;
    rsp0_d    = (state_d == DONE) && !gnt_d;
    rsp1_d    = (state_d == DONE) && gnt_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      op_q       <= '0;
      num1_q     <= '0;
      num2_q     <= '0;
      out_sel_q  <= '0;
      in_sel_q   <= SEL_RESET;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      alu_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      op_q       <= op_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      out_sel_q  <= out_sel_d;
      in_sel_q   <= in_sel_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      busy_q     <= busy_d;
      alu_on_q   <= 1'b1;
    end
  end

  assign state       = state_q;
  assign busy        = busy_q;
  assign alu_on      = alu_on_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = out_sel_q;
  assign rsp0_valid  = rsp0_q;
  assign rsp1_valid  = rsp1_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = CHK_EN ? rsp_err_q : 1'b0;

endmodule

// File: doc/alu_op_sched.md
ALU_OP_SCHED -- requirements
Module: alu_op_sched

Interface
REQ-001 SHALL have parameter: LAT, 2, ALU execute cycles between load and result capture (legal 1..15).
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock; all state on rising edge
  rst  in  1  asynchronous, active-high reset
  req0_valid  in  1  requester 0 command valid
  req0_ready  out  1  requester 0 command accepted this cycle
  req0_op  in  7  requester 0 one-hot operation select
  req0_a, req0_b  in  8 each  requester 0 operands
  req1_valid/req1_ready/req1_op/req1_a/req1_b  as requester 0, for requester 1
  rsp0_valid, rsp1_valid  out  1 each  one-cycle result pulse per requester
  rsp_data  out  8  result, shared, qualified by rspN_valid
  rsp_err  out  1  illegal-op flag, qualified by rspN_valid
  alu_on  out  1  ALU enable
  alu_in_sel  out  3  ALU input control {persist, load, reset}
  alu_num1, alu_num2  out  8 each  ALU operands
  alu_out_sel  out  7  ALU one-hot operation select
  alu_out  in  8  ALU result
  busy  out  1  high in any state except IDLE
  state  out  2  current FSM state encoding

Function
REQ-003 SHALL implement FSM IDLE=2'b00, LOAD=2'b01, EXEC=2'b10, DONE=2'b11; state port equals current state.
REQ-004 IDLE: SHALL grant one valid requester; reqN_ready SHALL be combinational, high only in IDLE for the granted requester; op, a, b, and grant id captured on that edge; next state LOAD.
REQ-005 Both valid in IDLE: SHALL grant the requester not granted last (round-robin); after reset requester 0 wins first tie.
REQ-006 A requester not granted SHALL hold valid and stable data; scheduler SHALL never drop or reorder a held request.
REQ-007 LOAD (1 cycle): alu_in_sel=3'b010, alu_num1/alu_num2/alu_out_sel = captured a/b/op; next EXEC with cycle counter loaded with LAT.
REQ-008 EXEC (exactly LAT cycles): alu_in_sel=3'b100, operands and out_sel held; on last EXEC edge alu_out registered into rsp_data; next DONE.
REQ-009 DONE (1 cycle): rspN_valid high for granted requester only, rsp_err=0; next IDLE. No response backpressure.
REQ-010 Latency: acceptance edge k -> rspN_valid high in cycle k+LAT+2; throughput one command per LAT+3 cycles.
REQ-011 IDLE/DONE: alu_in_sel=3'b100, alu_out_sel=7'b0, operands hold last values; alu_on=1 whenever rst low.
REQ-012 rsp_data/rsp_err SHALL hold value between pulses; rspN_valid never both high.
REQ-013 Counter SHALL be 4 bits; no wrap reachable for legal LAT.

Reset
REQ-014 While rst high: state=IDLE, alu_on=0, alu_in_sel=3'b001, alu_out_sel=0, alu_num1/2=0, rsp_data=0, rsp_err=0, rspN_valid=0, reqN_ready=0, busy=0, round-robin pointer=requester 0.
REQ-015 Reset mid-operation SHALL abort the in-flight command with no response; first post-reset command starts from IDLE.

Configuration
REQ-016 Macro ALU_SCHED_ONEHOT_CHK_EN defined: captured op not exactly one-hot SHALL go LOAD->DONE skipping EXEC, alu_in_sel stays 3'b100 in that LOAD, DONE pulses rspN_valid with rsp_err=1, rsp_data=0.
REQ-017 Macro undefined: op passed to ALU unchecked; rsp_err tied 0.

Verification (bench ALU stub: alu_out = num1+num2 when loaded with out_sel=7'b1000000)
REQ-018 LAT=2, req0 op=7'b1000000 a=8'h57 b=8'h1A -> ready at k, LOAD k+1, rsp0_valid at k+4 with rsp_data=8'h71, rsp_err=0.
REQ-019 req0 and req1 valid same cycle after reset -> req0 served first, req1 accepted on next IDLE, rsp1 pulse LAT+3 cycles after rsp0.
REQ-020 req1 held continuously with req0 re-requesting each IDLE -> grants alternate 0,1,0,1; no starvation.
REQ-021 rst asserted during EXEC -> outputs at REQ-014 values asynchronously; no rsp pulse; next command completes normally.
REQ-022 With ALU_SCHED_ONEHOT_CHK_EN, op=7'b0000011 -> rsp pulse at k+2 with rsp_err=1, rsp_data=0; alu_in_sel never 3'b010.
REQ-023 LAT=1 and LAT=15 -> rsp latency 3 and 17 cycles respectively.
